// File: rtl/bip2_control_unit_if.sv
// ============================================================================
// Module   : bip2_control_unit_if
// Purpose  : Bus bundle between the BIP-2 control unit and its datapath.
//            Optional single-step pins: BIP2_CTRL_SINGLE_STEP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bip2_control_unit_if #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  pmem_addr_o;
  logic [INSTR_W-1:0] pmem_data_i;
  logic [ADDR_W-1:0]  dmem_addr_o;
  logic               dmem_we_o;
  logic [15:0]        imm_o;
  logic               alu_sub_o;
  logic               alu_b_imm_o;
  logic [1:0]         acc_sel_o;
  logic               acc_en_o;
  logic               alu_zero_i;
  logic               alu_neg_i;
  logic               halted_o;
`ifdef BIP2_CTRL_SINGLE_STEP_EN
  logic               step_i;
  logic               waiting_o;

  modport master (
    output pmem_addr_o, dmem_addr_o, dmem_we_o, imm_o, alu_sub_o,
           alu_b_imm_o, acc_sel_o, acc_en_o, halted_o, waiting_o,
    input  pmem_data_i, alu_zero_i, alu_neg_i, step_i
  );
  modport slave (
    input  pmem_addr_o, dmem_addr_o, dmem_we_o, imm_o, alu_sub_o,
           alu_b_imm_o, acc_sel_o, acc_en_o, halted_o, waiting_o,
    output pmem_data_i, alu_zero_i, alu_neg_i, step_i
  );
`else
  modport master (
    output pmem_addr_o, dmem_addr_o, dmem_we_o, imm_o, alu_sub_o,
           alu_b_imm_o, acc_sel_o, acc_en_o, halted_o,
    input  pmem_data_i, alu_zero_i, alu_neg_i
  );
  modport slave (
    input  pmem_addr_o, dmem_addr_o, dmem_we_o, imm_o, alu_sub_o,
           alu_b_imm_o, acc_sel_o, acc_en_o, halted_o,
    output pmem_data_i, alu_zero_i, alu_neg_i
  );
`endif
endinterface

`default_nettype wire

// File: rtl/bip2_control_unit.sv
// ============================================================================
// Module   : bip2_control_unit
// Purpose  : Multicycle FETCH/DECODE/EXEC/MEM sequencer owning PC, IR, Z/N.
//            Optional single-step gating of FETCH: BIP2_CTRL_SINGLE_STEP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bip2_control_unit #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16
) (
  input  wire logic             CLOCK_i,
  input  wire logic             RESET_i,
  bip2_control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [4:0] c_op_hlt  = 5'b00000;
  localparam logic [4:0] c_op_sto  = 5'b00001;
  localparam logic [4:0] c_op_ld   = 5'b00010;
  localparam logic [4:0] c_op_ldi  = 5'b00011;
  localparam logic [4:0] c_op_add  = 5'b00100;
  localparam logic [4:0] c_op_addi = 5'b00101;
  localparam logic [4:0] c_op_sub  = 5'b00110;
  localparam logic [4:0] c_op_subi = 5'b00111;
  localparam logic [4:0] c_op_beq  = 5'b01000;
  localparam logic [4:0] c_op_bne  = 5'b01001;
  localparam logic [4:0] c_op_bgt  = 5'b01010;
  localparam logic [4:0] c_op_bge  = 5'b01011;
  localparam logic [4:0] c_op_blt  = 5'b01100;
  localparam logic [4:0] c_op_ble  = 5'b01101;
  localparam logic [4:0] c_op_jmp  = 5'b01110;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_z;
  logic                r_n;

  logic [4:0]          w_op;
  logic [ADDR_W-1:0]   w_operand;
  logic                w_taken;
  logic                w_pc_load;
  logic [ADDR_W-1:0]   w_pc_next;
  logic                w_ir_load;
  logic                w_flags_en;
  logic                w_we;
  logic                w_acc_en;
  logic [1:0]          w_acc_sel;
  logic                w_sub;
  logic                w_bimm;
  logic                w_halted;
`ifdef BIP2_CTRL_SINGLE_STEP_EN
  logic                w_waiting;
`endif

  assign w_op      = r_ir[INSTR_W-1 -: 5];
  assign w_operand = r_ir[ADDR_W-1:0];

  always_ff @(posedge CLOCK_i or posedge RESET_i) begin
    if (RESET_i) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_load)  r_ir <= bus.pmem_data_i;
      if (w_pc_load)  r_pc <= w_pc_next;
      if (w_flags_en) begin
        r_z <= bus.alu_zero_i;
        r_n <= bus.alu_neg_i;
      end
    end
  end

  // JMP shares the branch path as an always-taken condition
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      c_op_beq: w_taken = r_z;
      c_op_bne: w_taken = !r_z;
      c_op_bgt: w_taken = !r_z && !r_n;
      c_op_bge: w_taken = !r_n;
      c_op_blt: w_taken = r_n;
      c_op_ble: w_taken = r_z || r_n;
      c_op_jmp: w_taken = 1'b1;
      default:  w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pc_load  = 1'b0;
    w_pc_next  = r_pc;
    w_ir_load  = 1'b0;
    w_flags_en = 1'b0;
    w_we       = 1'b0;
    w_acc_en   = 1'b0;
    w_acc_sel  = 2'd0;
    w_sub      = 1'b0;
    w_bimm     = 1'b0;
    w_halted   = 1'b0;
`ifdef BIP2_CTRL_SINGLE_STEP_EN
    w_waiting  = 1'b0;
`endif
    case (r_state)
      ST_FETCH: begin
`ifdef BIP2_CTRL_SINGLE_STEP_EN
        w_waiting = 1'b1;
        if (bus.step_i) w_next = ST_DECODE;
`else
        w_next = ST_DECODE;
`endif
      end
      ST_DECODE: begin
        w_ir_load = 1'b1;
        w_pc_load = 1'b1;
        w_pc_next = r_pc + ADDR_W'(1);
        w_next    = ST_EXEC;
      end
      ST_EXEC: begin
        w_next = ST_FETCH;
        case (w_op)
          // halted_o rises with the HLT execute cycle, the moment sequencing stops
          c_op_hlt: begin
            w_next   = ST_HALT;
            w_halted = 1'b1;
          end
          c_op_sto: w_we = 1'b1;
          c_op_ldi: begin
            w_acc_sel = 2'd1;
            w_acc_en  = 1'b1;
          end
          c_op_addi, c_op_subi: begin
            w_bimm     = 1'b1;
            w_sub      = (w_op == c_op_subi);
            w_acc_en   = 1'b1;
            w_flags_en = 1'b1;
          end
          c_op_ld, c_op_add, c_op_sub: w_next = ST_MEM;
          c_op_beq, c_op_bne, c_op_bgt, c_op_bge, c_op_blt, c_op_ble, c_op_jmp: begin
            w_pc_load = w_taken;
            w_pc_next = w_operand;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        w_next   = ST_FETCH;
        w_acc_en = 1'b1;
        if (w_op == c_op_ld) begin
          w_acc_sel = 2'd2;
        end else begin
          w_sub      = (w_op == c_op_sub);
          w_flags_en = 1'b1;
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
        w_next   = ST_HALT;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  assign bus.pmem_addr_o = r_pc;
  assign bus.dmem_addr_o = w_operand;
  assign bus.imm_o       = {{(16-ADDR_W){w_operand[ADDR_W-1]}}, w_operand};
  assign bus.dmem_we_o   = w_we;
  assign bus.acc_en_o    = w_acc_en;
  assign bus.acc_sel_o   = w_acc_sel;
  assign bus.alu_sub_o   = w_sub;
  assign bus.alu_b_imm_o = w_bimm;
  assign bus.halted_o    = w_halted;
`ifdef BIP2_CTRL_SINGLE_STEP_EN
  assign bus.waiting_o   = w_waiting;
`endif

endmodule

`default_nettype wire
